matmul_pipe: RTL and testbench
==============================

MATMUL_PIPE -- requirements
Module: matmul_pipe

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the signed element width of X, Y and Z.
REQ-002 Parameter ADDR_WIDTH, default 12, SHALL set the width of every BRAM address port.
REQ-003 Parameter DIM_WIDTH, default 7, SHALL set the width of the runtime dimension inputs (max dimension 2^DIM_WIDTH-1).
REQ-004 Port clock, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1, SHALL be a synchronous, active-high reset.
REQ-006 Port start, input, 1, SHALL be the operation request, sampled only in IDLE.
REQ-007 Ports m_dim, k_dim, n_dim, input, DIM_WIDTH, SHALL give the matrix dimensions: X is MxK, Y is KxN and Z is MxN. They are latched when start is accepted.
REQ-008 Port busy, output, 1, SHALL be high in every state except IDLE.
REQ-009 Port done, output, 1, SHALL be a one-cycle completion pulse.
REQ-010 Ports x_addr and y_addr, output, ADDR_WIDTH, SHALL be the read addresses to the X and Y BRAMs.
REQ-011 Ports x_dout and y_dout, input, DATA_WIDTH, SHALL be the read data, valid one cycle after the address.
REQ-012 Ports z_addr (ADDR_WIDTH), z_din (DATA_WIDTH) and z_wr_en (1), output, SHALL be the Z BRAM write port.

Function
REQ-013 The block SHALL implement states IDLE, RUN, DRAIN and DONE.
REQ-014 The block SHALL make the following transitions:
- IDLE->RUN on start with all dimensions nonzero.
- IDLE->DONE on start with any dimension zero.
- RUN->DRAIN after the last address pair is issued.
- DRAIN->DONE after the final Z write.
- DONE->IDLE unconditionally.
REQ-015 In RUN, the block SHALL issue one address pair per cycle in i-major, j-middle, k-minor order, using x_addr=i*K+k and y_addr=k*N+j, truncated to ADDR_WIDTH.
REQ-016 Returned data SHALL be multiplied as signed values. The accumulator SHALL load the product when k=0 and add it otherwise, with results wrapping modulo 2^DATA_WIDTH.
REQ-017 The cycle after the product for k=K-1 is accumulated, the block SHALL assert z_wr_en for exactly one cycle with z_addr=i*N+j and z_din equal to the accumulator.
REQ-018 The block SHALL produce exactly M*N writes per operation, with one MAC per cycle and no bubbles between elements.
REQ-019 done SHALL assert exactly M*N*K+3 cycles after the edge that sampled start, in the cycle following the last write.
REQ-020 A zero-dimension start SHALL produce no writes and SHALL assert done 1 cycle after the sampling edge.
REQ-021 start SHALL be ignored while busy. Dimension input changes during an operation SHALL have no effect.
REQ-022 When not in RUN, x_addr and y_addr SHALL be 0. Whenever z_wr_en is low, z_addr and z_din SHALL be 0.

Reset
REQ-023 On reset, the state SHALL become IDLE and counters and accumulator SHALL clear. The outputs busy, done, z_wr_en, z_addr, z_din, x_addr and y_addr SHALL all be 0.
REQ-024 Reset asserted mid-operation SHALL abort the operation: no further Z write occurs, and the next start begins a fresh operation.

Configuration
REQ-025 With macro MATMUL_SAT_EN defined, accumulation SHALL saturate to the signed DATA_WIDTH range, so that overflow clamps to 2^(DATA_WIDTH-1)-1 and underflow to -2^(DATA_WIDTH-1).
REQ-026 Without MATMUL_SAT_EN, accumulation SHALL wrap as in REQ-016.

Structure
REQ-027 Package matmul_pkg SHALL hold the state enum type and the default parameter constants.
REQ-028 The multiply-accumulate stage, including the saturation option, SHALL be a sub-module matmul_mac. Address sequencing and the FSM SHALL stay in matmul_pipe.

Verification
REQ-029 M=K=N=2 with X=[[1,2],[3,4]] and Y=identity -> Z writes at addresses 0..3 of 1, 2, 3, 4, and done at cycle 11.
REQ-030 M=K=N=1 with X=-5 and Y=7 -> one write, z_addr=0 and z_din=-35, and done at cycle 4.
REQ-031 K=2, DATA_WIDTH=32, X=[0x7FFFFFFF,1] and Y=[1,1] -> z_din=0x80000000 without the macro, and 0x7FFFFFFF with MATMUL_SAT_EN.
REQ-032 start with n_dim=0 -> no z_wr_en, and done at cycle 1.
REQ-033 M=K=N=3 with reset asserted at cycle 10 -> no writes after reset; a restart yields all 9 correct writes.
REQ-034 start pulsed again mid-operation with different dimensions -> ignored; the original results and timing are unchanged.

Source files
------------

// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared state type and default parameters for matmul_pipe
package matmul_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 12;
    localparam int DEF_DIM_WIDTH  = 7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/matmul_mac.sv
// rtl/matmul_mac.sv - signed multiply-accumulate stage with one-cycle write strobe
// Optional saturation selected by macro MATMUL_SAT_EN (default: wrap modulo 2^DATA_WIDTH).
module matmul_mac #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  valid_i,
    input  logic                  first_i,
    input  logic                  last_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic [DATA_WIDTH-1:0] acc_o,
    output logic                  wr_o
);

    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic                  wr_q;

`ifdef MATMUL_SAT_EN
    logic [2*DATA_WIDTH-1:0] a_ext, b_ext, prod;
    logic [2*DATA_WIDTH:0]   sum;

    // Full-precision sum; clamp when the bits above the sign position disagree.
    always_comb begin
        a_ext = {{DATA_WIDTH{a_i[DATA_WIDTH-1]}}, a_i};
        b_ext = {{DATA_WIDTH{b_i[DATA_WIDTH-1]}}, b_i};
        prod  = a_ext * b_ext;
        sum   = first_i ? {prod[2*DATA_WIDTH-1], prod}
                        : ({{(DATA_WIDTH+1){acc_q[DATA_WIDTH-1]}}, acc_q} + {prod[2*DATA_WIDTH-1], prod});
        if (sum[2*DATA_WIDTH:DATA_WIDTH-1] == '0 || sum[2*DATA_WIDTH:DATA_WIDTH-1] == '1) begin
            acc_d = sum[DATA_WIDTH-1:0];
        end else if (sum[2*DATA_WIDTH]) begin
            acc_d = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            acc_d = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
    end
`else
    logic [DATA_WIDTH-1:0] prod;

    // Low half of a signed product equals the unsigned one, so wrap needs no extension.
    always_comb begin
        prod  = a_i * b_i;
        acc_d = first_i ? prod : acc_q + prod;
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q <= '0;
            wr_q  <= 1'b0;
        end else begin
            wr_q <= valid_i & last_i;
            if (valid_i) begin
                acc_q <= acc_d;
            end
        end
    end

    assign acc_o = acc_q;
    assign wr_o  = wr_q;

endmodule

// File: rtl/matmul_pipe.sv
// rtl/matmul_pipe.sv - BRAM-fed pipelined matrix multiply Z = X*Y, one MAC per cycle
// Macro MATMUL_SAT_EN (in matmul_mac) switches accumulation from wrap to saturate.
module matmul_pipe
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DIM_WIDTH  = DEF_DIM_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DIM_WIDTH-1:0]  m_dim,
    input  logic [DIM_WIDTH-1:0]  k_dim,
    input  logic [DIM_WIDTH-1:0]  n_dim,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] x_addr,
    output logic [ADDR_WIDTH-1:0] y_addr,
    input  logic [DATA_WIDTH-1:0] x_dout,
    input  logic [DATA_WIDTH-1:0] y_dout,
    output logic [ADDR_WIDTH-1:0] z_addr,
    output logic [DATA_WIDTH-1:0] z_din,
    output logic                  z_wr_en
);

    localparam int LW = 2 * DIM_WIDTH + 1;
    localparam logic [DIM_WIDTH-1:0] ONE = DIM_WIDTH'(1);

    state_t state_q, state_d;
    logic [DIM_WIDTH-1:0] m_q, kd_q, n_q, m_d, kd_d, n_d;
    logic [DIM_WIDTH-1:0] i_q, j_q, k_q, i_d, j_d, k_d;
    logic                 v1_q, first1_q, last1_q;
    logic [ADDR_WIDTH-1:0] zaddr1_q, zaddr2_q;
    logic [LW-1:0]        x_lin, y_lin, z_lin;
    logic                 in_run, accept, last_k, last_j, last_i, last_pair;
    logic [DATA_WIDTH-1:0] mac_acc;
    logic                 mac_wr;

    assign accept    = (state_q == S_IDLE) && start;
    assign last_k    = (k_q == kd_q - ONE);
    assign last_j    = (j_q == n_q - ONE);
    assign last_i    = (i_q == m_q - ONE);
    assign last_pair = last_i && last_j && last_k;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = (m_dim == '0 || k_dim == '0 || n_dim == '0) ? S_DONE : S_RUN;
            S_RUN:   if (last_pair) state_d = S_DRAIN;
            S_DRAIN: if (mac_wr && !v1_q) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy   = (state_q != S_IDLE);
        done   = (state_q == S_DONE);
        in_run = (state_q == S_RUN);
    end

    // i-major, j-middle, k-minor walk over the MxNxK iteration space.
    always_comb begin
        m_d  = m_q;
        kd_d = kd_q;
        n_d  = n_q;
        i_d  = i_q;
        j_d  = j_q;
        k_d  = k_q;
        if (accept) begin
            m_d  = m_dim;
            kd_d = k_dim;
            n_d  = n_dim;
            i_d  = '0;
            j_d  = '0;
            k_d  = '0;
        end else if (in_run) begin
            if (!last_k) begin
                k_d = k_q + ONE;
            end else begin
                k_d = '0;
                if (!last_j) begin
                    j_d = j_q + ONE;
                end else begin
                    j_d = '0;
                    if (!last_i) i_d = i_q + ONE;
                end
            end
        end
    end

    always_comb begin
        x_lin = LW'(i_q) * LW'(kd_q) + LW'(k_q);
        y_lin = LW'(k_q) * LW'(n_q) + LW'(j_q);
        z_lin = LW'(i_q) * LW'(n_q) + LW'(j_q);
    end

    // Stage 1 tracks the BRAM read latency; stage 2 holds the Z address until the write.
    always_ff @(posedge clock) begin
        if (reset) begin
            m_q      <= '0;
            kd_q     <= '0;
            n_q      <= '0;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            v1_q     <= 1'b0;
            first1_q <= 1'b0;
            last1_q  <= 1'b0;
            zaddr1_q <= '0;
            zaddr2_q <= '0;
        end else begin
            m_q      <= m_d;
            kd_q     <= kd_d;
            n_q      <= n_d;
            i_q      <= i_d;
            j_q      <= j_d;
            k_q      <= k_d;
            v1_q     <= in_run;
            first1_q <= (k_q == '0);
            last1_q  <= last_k;
            zaddr1_q <= ADDR_WIDTH'(z_lin);
            if (v1_q && last1_q) begin
                zaddr2_q <= zaddr1_q;
            end
        end
    end

    matmul_mac #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_mac (
        .clock   (clock),
        .reset   (reset),
        .valid_i (v1_q),
        .first_i (first1_q),
        .last_i  (last1_q),
        .a_i     (x_dout),
        .b_i     (y_dout),
        .acc_o   (mac_acc),
        .wr_o    (mac_wr)
    );

    assign x_addr  = in_run ? ADDR_WIDTH'(x_lin) : '0;
    assign y_addr  = in_run ? ADDR_WIDTH'(y_lin) : '0;
    assign z_wr_en = mac_wr;
    assign z_addr  = mac_wr ? zaddr2_q : '0;
    assign z_din   = mac_wr ? mac_acc : '0;

endmodule

// File: tb/tb_matmul_pipe.sv
// tb/tb_matmul_pipe.sv - scoreboard bench for matmul_pipe with BRAM models
module tb_matmul_pipe;

    logic        clock = 1'b0;
    logic        reset, start;
    logic [6:0]  m_dim, k_dim, n_dim;
    logic        busy, done, z_wr_en;
    logic [11:0] x_addr, y_addr, z_addr;
    logic [31:0] x_dout, y_dout, z_din;

    matmul_pipe dut (
        .clock(clock), .reset(reset), .start(start),
        .m_dim(m_dim), .k_dim(k_dim), .n_dim(n_dim),
        .busy(busy), .done(done),
        .x_addr(x_addr), .y_addr(y_addr), .x_dout(x_dout), .y_dout(y_dout),
        .z_addr(z_addr), .z_din(z_din), .z_wr_en(z_wr_en)
    );

    always #5 clock = ~clock;

    logic [31:0] xm [4096];
    logic [31:0] ym [4096];
    always @(posedge clock) begin
        x_dout <= xm[x_addr];
        y_dout <= ym[y_addr];
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int tests = 0, fails = 0, start_cyc = 0;
    logic [11:0] exp_a [$];
    logic [31:0] exp_d [$];
    int          exp_done [$];
    logic [11:0] ea;
    logic [31:0] ed;
    int          edn;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic expw(input logic [11:0] a, input logic [31:0] d);
        exp_a.push_back(a);
        exp_d.push_back(d);
    endtask

    // Monitor: every Z write and every done pulse is matched against the queues.
    always @(negedge clock) begin
        if (z_wr_en === 1'b1) begin
            if (exp_a.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_write: got addr %0h data %0h required no write", z_addr, z_din);
            end else begin
                ea = exp_a.pop_front();
                ed = exp_d.pop_front();
                check("z_addr", 64'(z_addr), 64'(ea));
                check("z_din", 64'(z_din), 64'(ed));
            end
        end
        if (done === 1'b1) begin
            if (exp_done.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_done: got done at cycle %0d required none", cyc - start_cyc + 1);
            end else begin
                edn = exp_done.pop_front();
                check("done_cycle", 64'(cyc - start_cyc + 1), 64'(edn));
            end
        end
    end

    task automatic start_op(input int m, input int k, input int n);
        @(negedge clock);
        m_dim = 7'(m); k_dim = 7'(k); n_dim = 7'(n);
        start = 1'b1;
        start_cyc = cyc + 1;
        @(negedge clock);
        start = 1'b0;
        m_dim = 7'h55; k_dim = 7'h2a; n_dim = 7'h13;
    endtask

    task automatic wait_done(input string name, input int bound);
        for (int i = 0; i < bound; i++) begin
            if (done === 1'b1) begin
                check({name, "_writes_left"}, 64'(exp_a.size()), 64'd0);
                return;
            end
            @(negedge clock);
        end
        tests++; fails++;
        $display("FAIL %s_timeout: got no done within %0d cycles required done", name, bound);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            xm[i] = '0;
            ym[i] = '0;
        end
        reset = 1'b1; start = 1'b0;
        m_dim = '0; k_dim = '0; n_dim = '0;
        repeat (3) @(negedge clock);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_zwr", 64'(z_wr_en), 64'd0);
        check("rst_zaddr_zdin", 64'({z_addr, z_din}), 64'd0);
        check("rst_xy_addr", 64'({x_addr, y_addr}), 64'd0);
        reset = 1'b0;

        // 2x2x2, X=[[1,2],[3,4]], Y=I
        xm[0] = 1; xm[1] = 2; xm[2] = 3; xm[3] = 4;
        ym[0] = 1; ym[1] = 0; ym[2] = 0; ym[3] = 1;
        expw(0, 1); expw(1, 2); expw(2, 3); expw(3, 4);
        exp_done.push_back(11);
        start_op(2, 2, 2);
        check("run_busy", 64'(busy), 64'd1);
        wait_done("ident", 50);

        // 1x1x1, -5 * 7
        xm[0] = -5; ym[0] = 7;
        expw(0, 32'hFFFF_FFDD);
        exp_done.push_back(4);
        start_op(1, 1, 1);
        wait_done("scalar", 20);

        // K=2 overflow: wrap or clamp
        xm[0] = 32'h7FFF_FFFF; xm[1] = 1; ym[0] = 1; ym[1] = 1;
`ifdef MATMUL_SAT_EN
        expw(0, 32'h7FFF_FFFF);
`else
        expw(0, 32'h8000_0000);
`endif
        exp_done.push_back(5);
        start_op(1, 2, 1);
        wait_done("overflow", 20);

        // K=1 back-to-back writes
        xm[0] = 2; ym[0] = 3; ym[1] = -4; ym[2] = 5;
        expw(0, 6); expw(1, 32'hFFFF_FFF8); expw(2, 10);
        exp_done.push_back(6);
        start_op(1, 1, 3);
        wait_done("k1", 20);

        // zero dimension
        exp_done.push_back(1);
        start_op(2, 2, 0);
        wait_done("zero_n", 10);

        // 3x3x3 aborted by reset in cycle 10: only elements 0 and 1 get written
        for (int i = 0; i < 9; i++) xm[i] = i + 1;
        ym[0] = 1; ym[1] = 0; ym[2] = 2;
        ym[3] = 0; ym[4] = 1; ym[5] = 0;
        ym[6] = 1; ym[7] = 1; ym[8] = -1;
        expw(0, 4); expw(1, 5);
        start_op(3, 3, 3);
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_zwr", 64'(z_wr_en), 64'd0);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        check("abort_writes_left", 64'(exp_a.size()), 64'd0);

        // restart: full 3x3 result
        expw(0, 4);  expw(1, 5);  expw(2, 32'hFFFF_FFFF);
        expw(3, 10); expw(4, 11); expw(5, 2);
        expw(6, 16); expw(7, 17); expw(8, 5);
        exp_done.push_back(30);
        start_op(3, 3, 3);
        wait_done("restart", 80);

        // start pulsed mid-operation with other dims is ignored
        xm[0] = 2; xm[1] = -1; xm[2] = 0; xm[3] = 3;
        ym[0] = 4; ym[1] = 5; ym[2] = 6; ym[3] = -7;
        expw(0, 2); expw(1, 17); expw(2, 18); expw(3, 32'hFFFF_FFEB);
        exp_done.push_back(11);
        start_op(2, 2, 2);
        repeat (2) @(negedge clock);
        m_dim = 1; k_dim = 1; n_dim = 1; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_done("restart_ignored", 50);
        repeat (5) @(negedge clock);
        check("idle_after", 64'(busy), 64'd0);
        check("done_left", 64'(exp_done.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
